uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 197 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART transmitter (8N1 frames).
// Define UART_TX_PARITY_EN to append an even-parity bit (8E1 frames).
module uart_tx_fifo #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int UART_BPS   = 10_000_000,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        uart_tx,
  output logic                        tx_busy,
  output logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int BPS_CNT = CLOCK_FREQ / UART_BPS;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CNTW    = AW + 1;
  localparam int CW      = (BPS_CNT > 2) ? $clog2(BPS_CNT) : 1;

  localparam logic [CW-1:0]   BIT_LAST = CW'(BPS_CNT - 1);
  localparam logic [CNTW-1:0] DEPTH_W  = CNTW'(FIFO_DEPTH);

  if (BPS_CNT < 2) begin : g_bps_chk
    $error("uart_tx_fifo: CLOCK_FREQ/UART_BPS must be at least 2");
  end

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
  begin : g_depth_chk
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      data_q, data_d;
  logic            tx_q, tx_d;
  logic [AW-1:0]   wr_q, wr_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic            push;
  logic            pop;
  logic            bit_end;
  logic            fifo_empty;
  logic [2:0]      nxt_bit;
  logic [7:0]      head;

  assign fifo_empty = (count_q == '0);
  assign tx_ready   = !sys_rst && (count_q < DEPTH_W);
  assign push       = tx_valid && tx_ready;
  assign head       = mem_q[rd_q];
  assign bit_end    = (cnt_q == BIT_LAST);
  assign nxt_bit    = bit_q + 3'd1;

  assign uart_tx    = tx_q;
  assign tx_busy    = (state_q != S_IDLE);
  assign tx_done    = !sys_rst && (state_q == S_STOP) && bit_end;
  assign fifo_count = count_q;

  // Frame sequencer: bit timing, line level and FIFO pop requests.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    data_d  = data_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    if (state_q == S_IDLE || bit_end) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = S_START;
          data_d  = head;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
          tx_d    = data_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = ^data_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d = nxt_bit;
            tx_d  = data_q[nxt_bit];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            // Back-to-back frame: the next start bit follows at once.
            pop     = 1'b1;
            state_d = S_START;
            data_d  = head;
            tx_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wr_d = push ? wr_q + AW'(1) : wr_q;
    rd_d = pop ? rd_q + AW'(1) : rd_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  // FSM state register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and FIFO control registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // FIFO storage; pointers alone define which entries are live.
  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem_q[wr_q] <= tx_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed + random checks of uart_tx_fifo
// against a cycle-count reference model of the serial frames.
module tb_uart_tx_fifo;

  localparam int CLK_HZ = 50_000_000;
  localparam int BAUD   = 10_000_000;
  localparam int DEPTH  = 16;
  localparam int BPS    = CLK_HZ / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS  = 11;
  localparam bit PAR    = 1'b1;
`else
  localparam int NBITS  = 10;
  localparam bit PAR    = 1'b0;
`endif
  localparam int FRAME  = NBITS * BPS;

  logic       sys_clk  = 1'b0;
  logic       sys_rst  = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_ready;
  logic       uart_tx;
  logic       tx_busy;
  logic       tx_done;
  logic [4:0] fifo_count;

  int total = 0;
  int bad   = 0;
  int cnt   = 0;

  uart_tx_fifo #(
    .CLOCK_FREQ(CLK_HZ),
    .UART_BPS  (BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .uart_tx   (uart_tx),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .fifo_count(fifo_count)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cnt <= cnt + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b,
                                     input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (PAR && idx == 9) return ^b;
    return 1'b1;
  endfunction

  // Reference model: queue of bytes waiting, plus cycles left
  // in the frame on the wire.
  logic [7:0] mq [$];
  logic [7:0] cur  = 8'h00;
  int         left = 0;
  logic       exp_rdy;
  logic       exp_tx;

  always @(negedge sys_clk) begin
    exp_tx = 1'b1;
    if (left > 0) exp_tx = frame_bit(cur, (FRAME - left) / BPS);
    exp_rdy = !sys_rst && (mq.size() < DEPTH);
    chk("m_uart_tx", uart_tx, exp_tx);
    chk("m_tx_busy", tx_busy, left > 0);
    chk("m_tx_done", tx_done, !sys_rst && left == 1);
    chk("m_fifo_count", fifo_count, mq.size());
    chk("m_tx_ready", tx_ready, exp_rdy);
    if (sys_rst) begin
      mq.delete();
      left = 0;
    end else begin
      if (left <= 1 && mq.size() > 0) begin
        cur  = mq.pop_front();
        left = FRAME;
      end else if (left > 0) begin
        left--;
      end
      if (tx_valid && exp_rdy) mq.push_back(tx_data);
    end
  end

  task automatic next_cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b, output int acc);
    bit ok = 1'b0;
    acc = -1;
    tx_valid = 1'b1;
    tx_data  = b;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge sys_clk);
      if (tx_ready === 1'b1) begin
        ok  = 1'b1;
        acc = cnt;
      end
      next_cyc();
    end
    tx_valid = 1'b0;
    chk("push_accepted", ok, 1);
  endtask

  task automatic wait_low(output int f);
    bit seen = 1'b0;
    f = -1;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge sys_clk);
      if (uart_tx === 1'b0) begin
        seen = 1'b1;
        f = cnt;
      end
      next_cyc();
    end
    chk("wait_start_bit", seen, 1);
  endtask

  task automatic wait_done(output int d);
    bit seen = 1'b0;
    d = -1;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge sys_clk);
      if (tx_done === 1'b1) begin
        seen = 1'b1;
        d = cnt;
      end
      next_cyc();
    end
    chk("wait_tx_done", seen, 1);
  endtask

  task automatic wait_idle();
    bit seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge sys_clk);
      if (tx_busy === 1'b0 && fifo_count === 5'd0) seen = 1'b1;
      next_cyc();
    end
    chk("wait_idle", seen, 1);
  endtask

  // Push one byte into an idle block and time its frame.
  task automatic single(input logic [7:0] b);
    int a, f, d;
    wait_idle();
    push(b, a);
    wait_low(f);
    // accepting edge ends cycle a, popping edge ends cycle a+1
    chk("single_fall_latency", f - a, 2);
    wait_done(d);
    chk("single_frame_len", d - f + 1, FRAME);
    @(negedge sys_clk);
    chk("single_idle_busy", tx_busy, 0);
    chk("single_idle_line", uart_tx, 1);
    next_cyc();
  endtask

  initial begin
    #500_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int a, a2, f, d, n_acc, f0, first_done, last_done;
    int dones, nd;
    int acc_at [18];

    // reset held for three edges
    repeat (3) begin
      @(negedge sys_clk);
      chk("rst_tx_ready", tx_ready, 0);
      chk("rst_uart_tx", uart_tx, 1);
      chk("rst_fifo_count", fifo_count, 0);
      chk("rst_tx_busy", tx_busy, 0);
      next_cyc();
    end
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("rst_release_ready", tx_ready, 1);
    next_cyc();

    // single frames
    single(8'h55);
    single(8'h07);
    single(8'hA3);

    // burst 0x00..0x11 with valid held high
    wait_idle();
    n_acc = 0;
    f0 = -1;
    first_done = -1;
    dones = 0;
    last_done = -1;
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    for (int c = 0; c < 2000 && n_acc < 18; c++) begin
      @(negedge sys_clk);
      if (n_acc == 17 && cnt == acc_at[16] + 1) begin
        chk("burst_full_ready", tx_ready, 0);
        chk("burst_full_count", fifo_count, DEPTH);
      end
      if (uart_tx === 1'b0 && f0 < 0) f0 = cnt;
      if (tx_done === 1'b1) begin
        if (first_done < 0) first_done = cnt;
        dones++;
        last_done = cnt;
      end
      if (tx_ready === 1'b1) begin
        acc_at[n_acc] = cnt;
        n_acc++;
      end
      next_cyc();
      tx_data = 8'(n_acc);
      if (n_acc == 18) tx_valid = 1'b0;
    end
    tx_valid = 1'b0;
    chk("burst_accepted", n_acc, 18);
    chk("burst_17_consec", acc_at[16] - acc_at[0], 16);
    chk("burst_18th_after_done", acc_at[17], first_done + 1);
    for (int c = 0; c < 2000 && dones < 18; c++) begin
      @(negedge sys_clk);
      if (tx_done === 1'b1) begin
        dones++;
        last_done = cnt;
      end
      next_cyc();
    end
    chk("burst_frames", dones, 18);
    chk("burst_span", last_done - f0 + 1, 18 * FRAME);

    // push and pop on the same edge at the end of a stop bit
    wait_idle();
    push(8'hA5, a);
    wait_low(f);
    push(8'h3C, a2);
    while (cnt < f + FRAME - 1) next_cyc();
    tx_valid = 1'b1;
    tx_data  = 8'hC3;
    @(negedge sys_clk);
    chk("pp_done", tx_done, 1);
    chk("pp_count_before", fifo_count, 1);
    chk("pp_ready", tx_ready, 1);
    next_cyc();
    tx_valid = 1'b0;
    @(negedge sys_clk);
    chk("pp_count_after", fifo_count, 1);
    chk("pp_next_start", uart_tx, 0);
    next_cyc();

    // reset in the middle of a frame with three bytes queued
    wait_idle();
    push(8'h11, a);
    push(8'h22, a2);
    push(8'h33, a2);
    push(8'h44, a2);
    f = a + 2;
    while (cnt < f + 20) next_cyc();
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("mid_rst_queued", fifo_count, 3);
    chk("mid_rst_busy", tx_busy, 1);
    next_cyc();
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("mid_rst_line", uart_tx, 1);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_busy_clr", tx_busy, 0);
    chk("mid_rst_ready", tx_ready, 1);
    next_cyc();
    nd = 0;
    repeat (3 * FRAME) begin
      @(negedge sys_clk);
      if (tx_done !== 1'b0 || uart_tx !== 1'b1) nd++;
      next_cyc();
    end
    chk("mid_rst_quiet", nd, 0);

    // random traffic, checked by the reference model
    for (int c = 0; c < 1500; c++) begin
      tx_valid = ($urandom_range(0, 3) == 0);
      tx_data  = 8'($urandom);
      next_cyc();
    end
    tx_valid = 1'b0;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
